// File: rtl/corescore_collector_uart.sv
// corescore_collector_uart: 8N1 UART receiver with a one-byte holding register.
// The line is synchronised, the start bit is validated at mid-bit, data bits are
// sampled every DIV cycles from that point, and the stop bit is checked before the
// byte is offered on a valid/ready interface. A frame that completes while the
// previous byte is still unconsumed is dropped and reported with o_overrun.
module corescore_collector_uart #(
    parameter int unsigned clk_freq_hz = 0,
    parameter int unsigned baud_rate   = 57600
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned DIV   = clk_freq_hz / baud_rate;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_t;

    logic             sync1;
    logic             rx_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shreg;
    logic [2:0]       idx;
    logic             sample;

    // cnt is loaded with the distance to the next sample instant and counts down;
    // the sample happens in the cycle where it reaches one.
    assign sample = (cnt == CNT_W'(1));

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= i_uart_rx;
            rx_s  <= sync1;
        end
    end

    // Receive FSM with the holding register and registered event pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= StIdle;
            cnt         <= '0;
            shreg       <= 8'h00;
            idx         <= 3'd0;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            // A byte loaded in StStop below overrides this clear.
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (!rx_s) begin
                        cnt   <= CNT_W'(HALF);
                        state <= StStart;
                    end
                end

                StStart: begin
                    if (sample) begin
                        if (rx_s) begin
                            // Line went back high by mid-start: treat as a glitch.
                            state <= StIdle;
                        end else begin
                            cnt   <= CNT_W'(DIV);
                            idx   <= 3'd0;
                            state <= StData;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                StData: begin
                    if (sample) begin
                        // LSB arrives first, so shift in from the top.
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= CNT_W'(DIV);
                        if (idx == 3'd7) begin
                            state <= StStop;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                StStop: begin
                    if (sample) begin
                        if (rx_s) begin
                            state <= StIdle;
                            if (!o_valid || i_ready) begin
                                o_data  <= shreg;
                                o_valid <= 1'b1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= StBreak;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                StBreak: begin
                    // Hold off until the line returns high so a break cannot
                    // look like a stream of zero-filled frames.
                    if (rx_s) begin
                        state <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_corescore_collector_uart.sv
// Bench for corescore_collector_uart: directed scenarios plus randomised traffic,
// checked every cycle against a frame-level model built from the recorded line.
module tb_corescore_collector_uart;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned DIV    = 16;
    localparam int unsigned HALF   = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       uart_rx = 1'b1;
    logic       ready   = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    corescore_collector_uart #(
        .clk_freq_hz(CLK_HZ),
        .baud_rate  (BAUD)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_uart_rx  (uart_rx),
        .o_data     (data),
        .o_valid    (valid),
        .i_ready    (ready),
        .o_frame_err(frame_err),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // The line level at every clock edge since reset is recorded; the receiver
    // sees the level from two edges earlier. Each frame is decoded from its
    // detection edge t0 by reading the record at t0+HALF+n*DIV.
    bit         hist[$];
    int         m_mode;   // 0 hunting for start, 1 inside a frame, 2 waiting out a break
    int         m_t0;
    int         m_k;
    bit         m_s;
    bit         m_cons;
    bit         m_good;
    logic [7:0] m_byte;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_ov;

    function automatic bit seen(int k);
        return (k < 2) ? 1'b1 : hist[k-2];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_mode    = 0;
            m_t0      = 0;
            m_byte    = 8'h00;
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            exp_fe    = 1'b0;
            exp_ov    = 1'b0;
        end else begin
            hist.push_back(uart_rx);
            m_k    = hist.size() - 1;
            m_s    = seen(m_k);
            m_cons = exp_valid && ready;
            m_good = 1'b0;
            exp_fe = 1'b0;
            exp_ov = 1'b0;
            case (m_mode)
                0: begin
                    if (!m_s) begin
                        m_t0   = m_k;
                        m_mode = 1;
                    end
                end
                1: begin
                    if (m_k == m_t0 + int'(HALF) && m_s) begin
                        m_mode = 0;
                    end else if (m_k == m_t0 + int'(HALF + 9 * DIV)) begin
                        for (int n = 0; n < 8; n++) begin
                            m_byte[n] = seen(m_t0 + int'(HALF) + (n + 1) * int'(DIV));
                        end
                        if (m_s) begin
                            m_good = 1'b1;
                            m_mode = 0;
                        end else begin
                            exp_fe = 1'b1;
                            m_mode = 2;
                        end
                    end
                end
                default: begin
                    if (m_s) m_mode = 0;
                end
            endcase
            if (m_good) begin
                if (!exp_valid || m_cons) begin
                    exp_data  = m_byte;
                    exp_valid = 1'b1;
                end else begin
                    exp_ov = 1'b1;
                end
            end else if (m_cons) begin
                exp_valid = 1'b0;
            end
        end
    end

    // ---------------- hand-computed literal expectations ----------------
    int         lit_n = 0;
    int         lit_cyc[32];
    logic       lit_v[32];
    logic [7:0] lit_d[32];
    logic       lit_fe[32];
    logic       lit_ov[32];

    task automatic add_lit(input int c, input logic v, input logic [7:0] d,
                           input logic fe, input logic ov);
        lit_cyc[lit_n] = c;
        lit_v[lit_n]   = v;
        lit_d[lit_n]   = d;
        lit_fe[lit_n]  = fe;
        lit_ov[lit_n]  = ov;
        lit_n          = lit_n + 1;
    endtask

    // ---------------- compare process ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("valid", {7'b0, valid}, {7'b0, exp_valid});
        chk("data", data, exp_data);
        chk("frame_err", {7'b0, frame_err}, {7'b0, exp_fe});
        chk("overrun", {7'b0, overrun}, {7'b0, exp_ov});
        for (int i = 0; i < lit_n; i++) begin
            if (lit_cyc[i] == cyc) begin
                chk("lit_valid", {7'b0, valid}, {7'b0, lit_v[i]});
                chk("lit_data", data, lit_d[i]);
                chk("lit_frame_err", {7'b0, frame_err}, {7'b0, lit_fe[i]});
                chk("lit_overrun", {7'b0, overrun}, {7'b0, lit_ov[i]});
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rand_ready = 1'b0;

    task automatic drive_bit(input logic b, input int n);
        repeat (n) begin
            @(negedge clk);
            uart_rx = b;
            if (rand_ready) ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    // Drives the first ncyc cycles of a frame (160 for a complete one).
    task automatic send(input logic [7:0] b, input logic stop, input int ncyc);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10 * int'(DIV) && i < ncyc; i++) begin
            @(negedge clk);
            uart_rx = fr[i/int'(DIV)];
            if (rand_ready) ready = 1'($urandom_range(0, 1));
        end
    endtask

    int c;
    int r;

    initial begin
        // Reset and idle line.
        @(negedge clk);
        add_lit(cyc + 1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(500);
        add_lit(cyc + 1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(4);

        // Good frame, then a back-to-back second frame.
        ready = 1'b1;
        c = cyc + 1;
        add_lit(c + 154, 1'b0, 8'h00, 1'b0, 1'b0);
        add_lit(c + 155, 1'b1, 8'hA5, 1'b0, 1'b0);
        add_lit(c + 156, 1'b0, 8'hA5, 1'b0, 1'b0);
        add_lit(c + 160 + 155, 1'b1, 8'h5A, 1'b0, 1'b0);
        send(8'hA5, 1'b1, 160);
        send(8'h5A, 1'b1, 160);
        idle(20);

        // Short glitch must not start a frame.
        drive_bit(1'b0, 4);
        idle(200);

        // Framing error, long break, recovery.
        c = cyc + 1;
        add_lit(c + 155, 1'b0, 8'h5A, 1'b1, 1'b0);
        add_lit(c + 156, 1'b0, 8'h5A, 1'b0, 1'b0);
        send(8'h3C, 1'b0, 160);
        drive_bit(1'b0, 40 * int'(DIV));
        idle(2 * int'(DIV));
        c = cyc + 1;
        add_lit(c + 155, 1'b1, 8'h55, 1'b0, 1'b0);
        send(8'h55, 1'b1, 160);
        idle(40);

        // Backpressure and overrun.
        ready = 1'b0;
        c = cyc + 1;
        add_lit(c + 155, 1'b1, 8'h11, 1'b0, 1'b0);
        add_lit(c + 160 + 154, 1'b1, 8'h11, 1'b0, 1'b0);
        add_lit(c + 160 + 155, 1'b1, 8'h11, 1'b0, 1'b1);
        add_lit(c + 160 + 156, 1'b1, 8'h11, 1'b0, 1'b0);
        send(8'h11, 1'b1, 160);
        send(8'h22, 1'b1, 160);
        idle(10);
        ready = 1'b1;
        add_lit(cyc + 1, 1'b0, 8'h11, 1'b0, 1'b0);
        idle(200);

        // Reset in the middle of data bit 3.
        send(8'hF0, 1'b1, 4 * int'(DIV) + 8);
        #2 rst_n = 1'b0;
        add_lit(cyc + 1, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        idle(10 * int'(DIV));
        c = cyc + 1;
        add_lit(c + 155, 1'b1, 8'h80, 1'b0, 1'b0);
        send(8'h80, 1'b1, 160);
        idle(40);

        // Randomised traffic with random consumer stalls.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                drive_bit(1'b0, int'($urandom_range(1, 7)));
                idle(20);
            end else if (r == 1) begin
                drive_bit(1'b0, int'($urandom_range(100, 400)));
                idle(20);
            end else begin
                send(8'($urandom), 1'($urandom_range(0, 5) != 0), 160);
                idle(int'($urandom_range(0, 30)));
            end
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        idle(300);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/corescore_collector_uart.md
# corescore_collector_uart

UART receiver for the corescore serial path. It is the inverse of the corescore UART emitter: it deserialises 8N1 frames from the serial line into bytes and presents them on a valid/ready byte interface. It sits between the board RX pin and any byte consumer, such as a loopback checker or a command parser. Sampling uses a 2-flop synchroniser, mid-bit start validation, stop-bit checking, and a one-byte holding register with overrun reporting.

## Interface
Parameters:
- clk_freq_hz, default 0: system clock frequency in Hz. Must be set by the instantiating module.
- baud_rate, default 57600: line rate in baud.
- Derived value DIV = clk_freq_hz/baud_rate (integer division). DIV ≥ 4 is required.
- Derived value HALF = DIV/2.

Ports (clock and reset first):
- i_clk, input, 1: sole clock. All logic is on the rising edge.
- i_rst_n, input, 1: reset, asynchronous and active-low (decided).
- i_uart_rx, input, 1: serial line. Asynchronous to i_clk. Idles high.
- o_data, output, 8: received byte. LSB is the first data bit on the wire.
- o_valid, output, 1: o_data holds an unconsumed byte.
- i_ready, input, 1: consumer accepts o_data when o_valid & i_ready.
- o_frame_err, output, 1: one-cycle pulse when a frame's stop bit is sampled low.
- o_overrun, output, 1: one-cycle pulse when a good frame completes while the held byte is unconsumed.

## Operation
- i_uart_rx passes through a 2-flop synchroniser to give rx_s. The synchroniser flops reset to 1.
- A bit counter cnt of width $clog2(DIV)+1 sets the spacing of sample instants. The shift register is 8 bits, and a bit index runs 0..7.
- States:
  - IDLE: when rx_s==0, load cnt=HALF and go to START.
  - START: at the sample instant, if rx_s==1 the start was false; go to IDLE with no output. Otherwise load cnt=DIV and go to DATA with index 0.
  - DATA: at each sample instant, shift rx_s in at the MSB (shift right, LSB-first wire order) and reload DIV. After index 7, go to STOP.
  - STOP: at the sample instant, rx_s==1 means a good frame; go to IDLE. rx_s==0 means a framing error: pulse o_frame_err, discard the byte, and go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line (break) from retriggering frames.
- Output register behaviour on a good frame:
  - If o_valid==0, or o_valid & i_ready in the same cycle: load o_data with the new byte and set o_valid=1.
  - Otherwise, keep the old o_data and o_valid, discard the new byte, and pulse o_overrun.
- o_valid clears on o_valid & i_ready unless a new byte loads in that same cycle.
- o_data is stable while o_valid==1 and is only replaced per the rule above.

## Timing
- Reset values (asynchronous, on i_rst_n low): state=IDLE, o_valid=0, o_data=0x00, o_frame_err=0, o_overrun=0, cnt=0, synchroniser=1. Reset mid-frame abandons the frame with no pulse.
- Latency from a pin edge to rx_s is 2 cycles.
- Let T0 be the first cycle IDLE sees rx_s==0. Sample instants are:
  - start bit at T0+HALF;
  - data bit n at T0+HALF+(n+1)·DIV;
  - stop bit at T0+HALF+9·DIV.
- o_valid, o_frame_err, or o_overrun asserts in the cycle after the stop sample, at T0+HALF+9·DIV+1.
- The FSM is in IDLE by T0+HALF+9·DIV+1, so a back-to-back start bit is detected with no dead time.
- Sample spacing is exactly DIV cycles with no cumulative drift.
- o_frame_err and o_overrun never assert together with a fresh o_valid rise for the same frame.

## Test plan
All scenarios use clk_freq_hz=1_600_000 and baud_rate=100_000, giving DIV=16 and HALF=8. T0 is the detection cycle.
- Reset / idle: hold the line high for 500 cycles after reset → o_valid=0, o_data=0x00, no pulses.
- Good frame: with i_ready=1, send 0xA5 → o_valid high for exactly 1 cycle at T0+153 with o_data=0xA5. Then send a back-to-back 0x5A → o_data=0x5A.
- Glitch: a 4-cycle low pulse on an idle line → no o_valid and no o_frame_err; FSM back in IDLE by T0+9.
- Framing error and break: send 0x3C with stop bit 0 → o_frame_err pulse at T0+153 and no o_valid. Then hold the line low for 40 bit times → no events. Release, wait 2 bit times, send 0x55 → o_valid with 0x55.
- Backpressure: with i_ready=0, send 0x11 then 0x22 → o_valid stays high with 0x11, and o_overrun pulses once at the end of the 0x22 frame. Raise i_ready → 0x11 is consumed, o_valid=0, and 0x22 is never presented.
- Reset mid-frame: pull i_rst_n low during data bit 3 of 0xF0 → all outputs are 0 immediately. Release, idle the line for 10 bit times, send 0x80 → o_valid with 0x80 at the expected cycle.
